// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one single-port memory between NREQ requesters.
// Bounded bursts per grant, registered one-hot grant, one-cycle read latency.
module mem_arb #(
    parameter int NREQ      = 4,
    parameter int ID_W      = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                     mem_arb_clk_ip,
    input  logic                     mem_arb_rst_ip,
    input  logic [NREQ-1:0]          mem_arb_req_ip,
    input  logic [NREQ-1:0]          mem_arb_we_ip,
    input  logic [NREQ*ADDR_W-1:0]   mem_arb_addr_ip,
    input  logic [NREQ*DATA_W-1:0]   mem_arb_wdata_ip,
    output logic [NREQ-1:0]          mem_arb_gnt_op,
    output logic                     mem_arb_rvalid_op,
    output logic [ID_W-1:0]          mem_arb_rid_op,
    output logic [DATA_W-1:0]        mem_arb_rdata_op,
    output logic                     mem_arb_busy_op
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0]   BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [ID_W-1:0] LAST_INIT  = ID_W'(NREQ - 1);

    typedef enum logic {IDLE, OWN} state_e;

    state_e              state_q;
    logic [ID_W-1:0]     owner_q;
    logic [ID_W-1:0]     last_q;
    logic [BW-1:0]       burst_q;
    logic [NREQ-1:0]     gnt_q;
    logic                rvalid_q;
    logic [ID_W-1:0]     rid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic [NREQ-1:0]     ownerOh;
    logic [NREQ-1:0]     others;
    logic                ownReq;
    logic                anyOther;
    logic                accWe;
    logic                access;
    logic                keep;
    logic [ADDR_W-1:0]   accAddr;
    logic [DATA_W-1:0]   accWdata;
    logic [ID_W-1:0]     idlePick;
    logic [ID_W-1:0]     rotPick;

    // Nearest set bit of mask strictly after 'from', wrapping; the far-to-near scan lets the nearest win.
    function automatic logic [ID_W-1:0] pickNext(input logic [NREQ-1:0] mask,
                                                 input logic [ID_W-1:0] from);
        logic [ID_W-1:0] sel;
        int idx;
        sel = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(from) + k) % NREQ;
            if (mask[idx]) sel = ID_W'(idx);
        end
        return sel;
    endfunction

    function automatic logic [NREQ-1:0] oneHot(input logic [ID_W-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        ownerOh  = oneHot(owner_q);
        others   = mem_arb_req_ip & ~ownerOh;
        ownReq   = |(mem_arb_req_ip & ownerOh);
        anyOther = |others;
        accWe    = |(mem_arb_we_ip & ownerOh);
        accAddr  = mem_arb_addr_ip[owner_q*ADDR_W +: ADDR_W];
        accWdata = mem_arb_wdata_ip[owner_q*DATA_W +: DATA_W];
        access   = (state_q == OWN) && ownReq;
        keep     = ownReq && ((burst_q < BURST_LAST) || !anyOther);
        idlePick = pickNext(mem_arb_req_ip, last_q);
        rotPick  = pickNext(others, owner_q);
    end

    always_ff @(posedge mem_arb_clk_ip or posedge mem_arb_rst_ip) begin
        if (mem_arb_rst_ip) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            last_q   <= LAST_INIT;
            burst_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            if (access && !accWe) begin
                rvalid_q <= 1'b1;
                rid_q    <= owner_q;
                rdata_q  <= mem[accAddr];
            end
            case (state_q)
                IDLE: begin
                    if (|mem_arb_req_ip) begin
                        state_q <= OWN;
                        owner_q <= idlePick;
                        gnt_q   <= oneHot(idlePick);
                        burst_q <= '0;
                    end
                end
                OWN: begin
                    if (keep) begin
                        if (burst_q < BURST_LAST) burst_q <= burst_q + BW'(1);
                    end else begin
                        last_q  <= owner_q;
                        burst_q <= '0;
                        if (anyOther) begin
                            owner_q <= rotPick;
                            gnt_q   <= oneHot(rotPick);
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory array is deliberately left out of reset.
    always_ff @(posedge mem_arb_clk_ip) begin
        if (access && accWe) mem[accAddr] <= accWdata;
    end

    assign mem_arb_gnt_op    = gnt_q;
    assign mem_arb_rvalid_op = rvalid_q;
    assign mem_arb_rid_op    = rid_q;
    assign mem_arb_rdata_op  = rdata_q;
    assign mem_arb_busy_op   = |gnt_q;

endmodule
